// File: rtl/acciones_botones_pkg.sv
// Shared action codes, code bit layout and press-FSM state encoding for the button front end.
// The Estados core imports the same package so both sides agree on the command encoding.
package acciones_botones_pkg;

  localparam int unsigned NUM_BTN = 3;

  localparam logic [2:0] ACC_NONE      = 3'd0;
  localparam logic [2:0] ACC_ALIMENTAR = 3'd1;
  localparam logic [2:0] ACC_DORMIR    = 3'd2;
  localparam logic [2:0] ACC_CURAR     = 3'd3;
  localparam int unsigned ACC_LARGO    = 2;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PULSADO = 2'd1,
    LARGO   = 2'd2
  } estado_e;

  function automatic logic [2:0] acc_code(input logic [1:0] idx, input logic largo);
    logic [2:0] c;
    unique case (idx)
      2'd0:    c = ACC_ALIMENTAR;
      2'd1:    c = ACC_DORMIR;
      2'd2:    c = ACC_CURAR;
      default: c = ACC_NONE;
    endcase
    c[ACC_LARGO] = largo;
    return c;
  endfunction

endpackage

// File: rtl/acciones_botones_antirrebote.sv
// One-bit 2-FF synchronizer plus debounce filter for an active-low raw button.
// o_pulsado is the debounced pressed level (active-high).
module acciones_botones_antirrebote #(
  parameter int unsigned DEBOUNCE_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_pulsado
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_estable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_estable <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      // Any agreeing cycle restarts the stability window.
      if (r_sync2 == r_estable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_estable <= r_sync2;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulsado = ~r_estable;

endmodule

// File: rtl/acciones_botones.sv
// Button front end: debounce, short/long press classification, arbitration and a one-entry
// valid/ready output buffer. Define ACC_AUTOREPEAT_EN to re-emit long codes while held.
module acciones_botones
  import acciones_botones_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter int unsigned LONG_CYC     = 50000,
  parameter int unsigned REPEAT_CYC   = 20000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_btn_n,
  output logic       o_accion_valid,
  output logic [2:0] o_accion_code,
  input  logic       i_accion_ready,
  output logic       o_accion_perdida,
  output logic [2:0] o_btn_estado
);

  localparam int unsigned HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] HC_MAX = HW'(LONG_CYC - 1);

  logic [NUM_BTN-1:0] w_pulsado;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    acciones_botones_antirrebote #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_antirrebote (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn_n  (i_btn_n[g]),
      .o_pulsado(w_pulsado[g])
    );
  end

  estado_e            r_est  [NUM_BTN];
  estado_e            w_est_d[NUM_BTN];
  logic [HW-1:0]      r_hc   [NUM_BTN];
  logic [HW-1:0]      w_hc_d [NUM_BTN];
  logic [NUM_BTN-1:0] w_ev;
  logic [NUM_BTN-1:0] w_ev_largo;

`ifdef ACC_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] r_rep  [NUM_BTN];
  logic [RW-1:0] w_rep_d[NUM_BTN];
`else
  logic w_unused_rep;
  assign w_unused_rep = |REPEAT_CYC;
`endif

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      w_est_d[i]    = r_est[i];
      w_hc_d[i]     = r_hc[i];
      w_ev[i]       = 1'b0;
      w_ev_largo[i] = 1'b0;
`ifdef ACC_AUTOREPEAT_EN
      w_rep_d[i]    = r_rep[i];
`endif
      unique case (r_est[i])
        REPOSO: begin
          if (w_pulsado[i]) begin
            w_est_d[i] = PULSADO;
            w_hc_d[i]  = '0;
          end
        end
        PULSADO: begin
          if (!w_pulsado[i]) begin
            w_ev[i]    = 1'b1;
            w_est_d[i] = REPOSO;
          end else if (r_hc[i] == HC_MAX) begin
            w_ev[i]       = 1'b1;
            w_ev_largo[i] = 1'b1;
            w_est_d[i]    = LARGO;
            w_hc_d[i]     = r_hc[i] + 1'b1;  // parks at LONG_CYC until the next press
`ifdef ACC_AUTOREPEAT_EN
            w_rep_d[i]    = '0;
`endif
          end else begin
            w_hc_d[i] = r_hc[i] + 1'b1;
          end
        end
        LARGO: begin
          if (!w_pulsado[i]) begin
            w_est_d[i] = REPOSO;
`ifdef ACC_AUTOREPEAT_EN
          end else if (r_rep[i] == REP_MAX) begin
            w_ev[i]       = 1'b1;
            w_ev_largo[i] = 1'b1;
            w_rep_d[i]    = '0;
          end else begin
            w_rep_d[i] = r_rep[i] + 1'b1;
`endif
          end
        end
        default: w_est_d[i] = REPOSO;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_est[i] <= REPOSO;
        r_hc[i]  <= '0;
`ifdef ACC_AUTOREPEAT_EN
        r_rep[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_est[i] <= w_est_d[i];
        r_hc[i]  <= w_hc_d[i];
`ifdef ACC_AUTOREPEAT_EN
        r_rep[i] <= w_rep_d[i];
`endif
      end
    end
  end

  logic [2:0] w_code;
  logic       w_any;
  logic       w_multi;
  logic       w_carga;

  // Scan from the top so the lowest-index event is the one left standing.
  always_comb begin
    w_code = ACC_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_ev[i]) begin
        w_code = acc_code(2'(i), w_ev_largo[i]);
      end
    end
  end

  logic       r_valid;
  logic [2:0] r_code;
  logic       r_perdida;

  assign w_any   = |w_ev;
  assign w_multi = |(w_ev & (w_ev - 1'b1));
  assign w_carga = w_any && (!r_valid || i_accion_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_code    <= ACC_NONE;
      r_perdida <= 1'b0;
    end else begin
      if (w_carga) begin
        r_valid <= 1'b1;
        r_code  <= w_code;
      end else if (r_valid && i_accion_ready) begin
        r_valid <= 1'b0;
        r_code  <= ACC_NONE;
      end
      r_perdida <= w_multi || (w_any && r_valid && !i_accion_ready);
    end
  end

  assign o_accion_valid   = r_valid;
  assign o_accion_code    = r_code;
  assign o_accion_perdida = r_perdida;
  assign o_btn_estado     = w_pulsado;

endmodule
